custom_leds_avs: RTL

Avalon-MM responder for the `Custom_leds_0_s0` bus that the HPS-side interconnect drives through the LW bridge. It terminates that bus and holds a data and a control register. From those it generates an 8-bit LED pattern with four selectable modes: static, blink, rotate and PWM dim. The block sits in the FPGA top level next to `soc_system`, taking its address/read/write/writedata and returning readdata.

---
 rtl/custom_leds_pkg.sv | 25 ++
 rtl/custom_leds_avs_tick_gen.sv | 38 +++
 rtl/custom_leds_avs.sv | 136 +++++++++++++
 3 files changed

// File: rtl/custom_leds_pkg.sv
// Shared definitions for the custom LED Avalon-MM responder:
// the LED mode encoding, register addresses and CTRL field positions.
package custom_leds_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_ROTATE = 2'b10,
    MODE_PWM    = 2'b11
  } led_mode_e;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_MODE_MSB = 1;
  localparam int CTRL_DUTY_LSB = 8;
  localparam int CTRL_DUTY_MSB = 15;
  localparam int CTRL_RATE_LSB = 16;
  localparam int CTRL_RATE_MSB = 31;

  localparam int DATA_LSB = 0;
  localparam int DATA_MSB = 7;

endpackage

// File: rtl/custom_leds_avs_tick_gen.sv
// Prescaler for the LED pattern engine: counts 0..rate and pulses tick for
// one clock when the count reaches rate, giving a tick period of rate+1.
module led_tick_gen
  import custom_leds_pkg::*;
#(
  parameter int RATE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [RATE_WIDTH-1:0] rate,
  output logic                  tick
);

  logic [RATE_WIDTH-1:0] cnt_q;
  logic [RATE_WIDTH-1:0] cnt_d;

  // A clear cycle never ticks, so a CTRL write restarts the period cleanly.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q + 1'b1;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q >= rate) begin
      tick  = 1'b1;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/custom_leds_avs.sv
// Avalon-MM responder with DATA and CTRL registers that drives an 8-bit LED
// pattern in static, blink, rotate or PWM-dim mode.
module custom_leds_avs
  import custom_leds_pkg::*;
#(
  parameter int LED_WIDTH  = 8,
  parameter int RATE_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 avs_s0_address,
  input  logic                 avs_s0_read,
  output logic [31:0]          avs_s0_readdata,
  input  logic                 avs_s0_write,
  input  logic [31:0]          avs_s0_writedata,
  output logic [LED_WIDTH-1:0] leds
);

  logic [LED_WIDTH-1:0]  data_q, data_d;
  led_mode_e             mode_q, mode_d;
  logic [7:0]            duty_q, duty_d;
  logic [RATE_WIDTH-1:0] rate_q, rate_d;
  logic                  phase_q, phase_d;
  logic [LED_WIDTH-1:0]  rot_q, rot_d;
  logic [7:0]            pwm_cnt_q, pwm_cnt_d;
  logic [LED_WIDTH-1:0]  leds_q, leds_d;
  logic [31:0]           readdata_q, readdata_d;

  logic wr_data;
  logic wr_ctrl;
  logic tick;
  logic unused_wdata;

  assign wr_data      = avs_s0_write && (avs_s0_address == ADDR_DATA);
  assign wr_ctrl      = avs_s0_write && (avs_s0_address == ADDR_CTRL);
  assign unused_wdata = ^avs_s0_writedata[CTRL_DUTY_LSB-1:CTRL_MODE_MSB+1];

  led_tick_gen #(
    .RATE_WIDTH(RATE_WIDTH)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (wr_ctrl),
    .rate  (rate_q),
    .tick  (tick)
  );

  always_comb begin
    data_d    = data_q;
    mode_d    = mode_q;
    duty_d    = duty_q;
    rate_d    = rate_q;
    phase_d   = phase_q;
    rot_d     = rot_q;
    pwm_cnt_d = pwm_cnt_q + 8'd1;

    if (wr_data) begin
      data_d = avs_s0_writedata[DATA_MSB:DATA_LSB];
    end
    if (wr_ctrl) begin
      mode_d = led_mode_e'(avs_s0_writedata[CTRL_MODE_MSB:CTRL_MODE_LSB]);
      duty_d = avs_s0_writedata[CTRL_DUTY_MSB:CTRL_DUTY_LSB];
      rate_d = avs_s0_writedata[CTRL_RATE_LSB +: RATE_WIDTH];
    end

    if (wr_ctrl) begin
      phase_d = 1'b0;
    end else if (tick) begin
      phase_d = ~phase_q;
    end

    // Any reload takes priority over a rotate step landing on the same edge.
    if (wr_ctrl) begin
      rot_d = data_q;
    end else if (wr_data) begin
      rot_d = avs_s0_writedata[DATA_MSB:DATA_LSB];
    end else if (tick && (mode_q == MODE_ROTATE)) begin
      rot_d = {rot_q[LED_WIDTH-2:0], rot_q[LED_WIDTH-1]};
    end
  end

  always_comb begin
    leds_d = '0;
    case (mode_q)
      MODE_STATIC: leds_d = data_q;
      MODE_BLINK:  leds_d = phase_q ? '0 : data_q;
      MODE_ROTATE: leds_d = rot_q;
      MODE_PWM:    leds_d = (pwm_cnt_q < duty_q) ? data_q : '0;
      default:     leds_d = '0;
    endcase
  end

  // Read data comes from pre-edge state, so a colliding write is not visible.
  always_comb begin
    readdata_d = readdata_q;
    if (avs_s0_read) begin
      readdata_d = '0;
      if (avs_s0_address == ADDR_DATA) begin
        readdata_d[DATA_MSB:DATA_LSB]                   = data_q;
        readdata_d[DATA_MSB+LED_WIDTH:DATA_LSB+LED_WIDTH] = leds_q;
      end else begin
        readdata_d[CTRL_MODE_MSB:CTRL_MODE_LSB]  = mode_q;
        readdata_d[CTRL_DUTY_MSB:CTRL_DUTY_LSB]  = duty_q;
        readdata_d[CTRL_RATE_LSB +: RATE_WIDTH]  = rate_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= '0;
      mode_q     <= MODE_STATIC;
      duty_q     <= '0;
      rate_q     <= '0;
      phase_q    <= 1'b0;
      rot_q      <= '0;
      pwm_cnt_q  <= '0;
      leds_q     <= '0;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      mode_q     <= mode_d;
      duty_q     <= duty_d;
      rate_q     <= rate_d;
      phase_q    <= phase_d;
      rot_q      <= rot_d;
      pwm_cnt_q  <= pwm_cnt_d;
      leds_q     <= leds_d;
      readdata_q <= readdata_d;
    end
  end

  assign leds            = leds_q;
  assign avs_s0_readdata = readdata_q;

endmodule
